// File: rtl/router_sync_ctrl_n.sv
// router_sync_ctrl_n: synchroniser between the router FSM, the register block and
// NUM_PORTS output FIFOs. It latches and decodes the destination address, registers
// the per-port valid flags, and runs one timeout FSM per port that soft-resets a FIFO
// whose data has been left unread for TIMEOUT cycles.
// Optional feature: define ROUTER_SYNC_DROP_CNT_EN to add per-port saturating
// soft-reset (drop) counters on the drop_cnt output.
module router_sync_ctrl_n #(
    parameter int unsigned NUM_PORTS = 3,
    parameter int unsigned ADDR_W    = 2,
    parameter int unsigned TIMEOUT   = 30
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [ADDR_W-1:0]      data_in,
    input  logic                   detect_add,
    input  logic                   write_enb_reg,
    input  logic [NUM_PORTS-1:0]   empty,
    input  logic [NUM_PORTS-1:0]   full,
    input  logic [NUM_PORTS-1:0]   read_enb,
    output logic [NUM_PORTS-1:0]   write_enb,
    output logic                   fifo_full,
    output logic                   addr_err,
    output logic [NUM_PORTS-1:0]   vld_out,
    output logic [NUM_PORTS-1:0]   soft_reset
`ifdef ROUTER_SYNC_DROP_CNT_EN
    ,
    output logic [NUM_PORTS*8-1:0] drop_cnt
`endif
);

    localparam int unsigned CntW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {StIdle, StCount, StSrst} state_e;

    logic [ADDR_W-1:0]    r_addr;
    logic                 r_addr_err;
    logic [NUM_PORTS-1:0] r_vld;
    logic [NUM_PORTS-1:0] r_srst;
    state_e               r_state [NUM_PORTS];
    state_e               w_state_d [NUM_PORTS];
    logic [CntW-1:0]      r_cnt [NUM_PORTS];
    logic [CntW-1:0]      w_cnt_d [NUM_PORTS];
    logic [NUM_PORTS-1:0] w_write_enb;
    logic                 w_fifo_full;

    // Latch the destination address and its range check on header detect.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_addr     <= '0;
            r_addr_err <= 1'b0;
        end else if (detect_add) begin
            r_addr     <= data_in;
            r_addr_err <= (32'(data_in) >= NUM_PORTS);
        end
    end

    // Decode latched address into one-hot write enable and selected full flag.
    always_comb begin
        w_write_enb = '0;
        w_fifo_full = 1'b0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            if (!reset && !r_addr_err && (32'(r_addr) == i)) begin
                w_write_enb[i] = write_enb_reg;
                w_fifo_full    = full[i];
            end
        end
    end

    assign write_enb = w_write_enb;
    assign fifo_full = w_fifo_full;
    assign addr_err  = r_addr_err;

    // Per-port timeout next-state: count consecutive unread-valid samples.
    always_comb begin
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            w_state_d[i] = r_state[i];
            w_cnt_d[i]   = r_cnt[i];
            unique case (r_state[i])
                StIdle: begin
                    if (r_vld[i] && !read_enb[i]) begin
                        w_state_d[i] = StCount;
                        w_cnt_d[i]   = CntW'(1);
                    end
                end
                StCount: begin
                    if (!(r_vld[i] && !read_enb[i])) begin
                        w_state_d[i] = StIdle;
                        w_cnt_d[i]   = '0;
                    end else if (r_cnt[i] == CntW'(TIMEOUT - 1)) begin
                        w_state_d[i] = StSrst;
                    end else begin
                        w_cnt_d[i] = r_cnt[i] + CntW'(1);
                    end
                end
                StSrst: begin
                    // The pulse cycle ignores cond; counting resumes from idle.
                    w_state_d[i] = StIdle;
                    w_cnt_d[i]   = '0;
                end
                default: begin
                    w_state_d[i] = StIdle;
                    w_cnt_d[i]   = '0;
                end
            endcase
        end
    end

    // Valid flags, timeout state and the registered soft-reset decode.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_vld  <= '0;
            r_srst <= '0;
            for (int unsigned i = 0; i < NUM_PORTS; i++) begin
                r_state[i] <= StIdle;
                r_cnt[i]   <= '0;
            end
        end else begin
            r_vld <= ~empty;
            for (int unsigned i = 0; i < NUM_PORTS; i++) begin
                r_state[i] <= w_state_d[i];
                r_cnt[i]   <= w_cnt_d[i];
                r_srst[i]  <= (r_state[i] == StSrst);
            end
        end
    end

    assign vld_out    = r_vld;
    assign soft_reset = r_srst;

`ifdef ROUTER_SYNC_DROP_CNT_EN
    logic [NUM_PORTS*8-1:0] r_drop;

    // Saturating count of soft-reset pulses per port.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_drop <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_PORTS; i++) begin
                if (r_srst[i] && (r_drop[i*8 +: 8] != 8'hFF)) begin
                    r_drop[i*8 +: 8] <= r_drop[i*8 +: 8] + 8'd1;
                end
            end
        end
    end

    assign drop_cnt = r_drop;
`endif

endmodule

// File: doc/router_sync_ctrl_n.md
Name: router_sync_ctrl_n

Overview:
- Parametrised N-port synchroniser between the router FSM, the router register block and NUM_PORTS output FIFOs.
- Latches the destination address when the header is detected, and decodes it into the one-hot FIFO write enables and the selected-FIFO full flag.
- Registers the per-port valid outputs.
- Runs one timeout state machine per port, which soft-resets any FIFO whose data is left unread for TIMEOUT cycles.

Parameters:
- NUM_PORTS, 3, number of output FIFOs/ports; legal range 2..16.
- ADDR_W, 2, width of the address field on data_in; must satisfy 2**ADDR_W >= NUM_PORTS.
- TIMEOUT, 30, consecutive unread-valid cycles before soft reset; legal range 2..255.

Ports:
- clock  in  1  system clock, all logic on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- data_in  in  ADDR_W  address field of the header byte.
- detect_add  in  1  header-detect strobe from the router FSM.
- write_enb_reg  in  1  FSM request to write the current byte.
- empty  in  NUM_PORTS  per-FIFO empty flags.
- full  in  NUM_PORTS  per-FIFO full flags.
- read_enb  in  NUM_PORTS  per-port read enables from the downstream readers.
- write_enb  out  NUM_PORTS  one-hot FIFO write enable.
- fifo_full  out  1  full flag of the addressed FIFO.
- addr_err  out  1  latched address is >= NUM_PORTS.
- vld_out  out  NUM_PORTS  registered not-empty flags.
- soft_reset  out  NUM_PORTS  one-cycle FIFO soft-reset pulses.

Behaviour:
- Reset (asynchronous, any time, including mid-packet or mid-count) clears:
  - addr_reg to 0 and addr_err to 0;
  - vld_out to 0 and soft_reset to 0;
  - all timeout counters to 0 and all port FSMs to IDLE.
  - write_enb and fifo_full therefore read 0 while reset is held.
- Address latch:
  - Rising edge with detect_add=1: addr_reg <= data_in and addr_err <= (data_in >= NUM_PORTS).
  - Otherwise both hold.
  - Latency is 1 cycle: a write_enb_reg in the same cycle as detect_add uses the previous addr_reg.
- write_enb (combinational): one-hot bit addr_reg when write_enb_reg=1 and addr_err=0; otherwise all zeros. Never more than one bit set.
- fifo_full (combinational): full[addr_reg] when addr_err=0; otherwise 0.
- vld_out[i]: registered ~empty[i], 1-cycle latency, no other qualification.
- Per-port timeout FSM, one instance per port i. Define cond = vld_out[i] & ~read_enb[i], sampled at the rising edge.
  - IDLE: cnt=0. cond=1 -> COUNT with cnt=1.
  - COUNT: cond=0 -> IDLE with cnt=0. cond=1 and cnt==TIMEOUT-1 -> SRST. cond=1 otherwise -> cnt+1.
  - SRST: soft_reset[i]=1 for exactly this one cycle, then unconditionally IDLE with cnt=0.
  - soft_reset is a registered decode of state==SRST. It first rises TIMEOUT edges after the first edge that samples cond=1.
  - read_enb[i]=1 on the edge that would have been the TIMEOUT-th sample: no pulse, FSM returns to IDLE.
  - After SRST, the FIFO clears and vld_out drops; if vld_out stays high, a new count starts from IDLE.
  - Counter width is clog2(TIMEOUT+1); no wrap is reachable.
- Ports are fully independent: simultaneous timeouts on several ports each pulse in the same cycle.
- An address change mid-count has no effect on the timeout FSMs.

Optional Feature:
- Macro: ROUTER_SYNC_DROP_CNT_EN.
- Defined:
  - Adds output port drop_cnt  out  NUM_PORTS*8  per-port counters, port i at bits [8i+7:8i].
  - Each counter increments on every cycle soft_reset[i]=1 and saturates at 255.
  - Counters are cleared only by reset.
- Undefined: the port and the counters are absent; all other behaviour is identical.

Test Plan:
- Reset mid-count: assert reset with port 1 at cnt=15 -> all outputs 0 immediately; after release, a fresh count restarts from 0 and the pulse arrives 30 edges after the new first cond sample.
- Address decode: detect_add=1 with data_in=2'b10, then write_enb_reg=1 -> write_enb=3'b100; drive full=3'b100 -> fifo_full=1; drive full=3'b011 -> fifo_full=0.
- Illegal address: detect_add with data_in=2'b11, NUM_PORTS=3 -> addr_err=1, write_enb=3'b000 under write_enb_reg=1, fifo_full=0. A following detect_add with 2'b01 -> addr_err=0, write_enb=3'b010.
- Timeout: empty[0]=0, read_enb[0]=0 held -> vld_out[0]=1 one cycle later; soft_reset[0]=1 for exactly one cycle 30 edges after the first cond sample; with the macro defined, drop_cnt[7:0]=1.
- Rescue at boundary: same as the timeout case, but read_enb[0]=1 on the 30th sample edge -> soft_reset[0] never asserts and cnt returns to 0.
- Parallel ports: NUM_PORTS=4, TIMEOUT=5, ports 0 and 3 stalled together -> both soft_reset bits pulse in the same cycle; ports 1 and 2 stay 0.
